ternary_sram_banked: RTL and testbench
======================================

Name: ternary_sram_banked

Overview:
Parametrised multi-bank PT-5 ternary SRAM. It supplies NUM_BANKS independent single-port banks, for example weights, inputs and partial sums, each with a valid/ready request channel and a fixed-latency response.
- Adds a post-reset scrub FSM that fills every bank with the PT-5 ternary-zero code.
- Adds a configurable read pipeline (1 or 2 cycles).
- Adds PT-5 code validation on writes.

It sits between the fabric DMA/loader and the ternary lanes, replacing the fixed dual-bank store.

Parameters:
NUM_BANKS, 2, number of independent banks/channels (1..8)
ADDR_WIDTH, 12, address bits per bank; depth = 2**ADDR_WIDTH bytes
DATA_WIDTH, 8, bits per word; one PT-5 byte (5 trits)
READ_LATENCY, 1, cycles from accepted read to rsp_valid; legal values 1 or 2
ZERO_CODE, 121, PT-5 encoding of five 0-trits (trit map -1/0/+1 -> 0/1/2)
MAX_CODE, 242, largest legal PT-5 code (3^5-1)

Ports:
clk  in  1  clock; all logic on rising edge
rst_n  in  1  asynchronous active-low reset
init_start  in  1  request a re-scrub of all banks
init_busy  out  1  scrub in progress
init_done  out  1  one-cycle pulse on the last scrub write
req_valid  in  NUM_BANKS  per-bank request valid
req_ready  out  NUM_BANKS  per-bank request ready
req_we  in  NUM_BANKS  1 = write, 0 = read
req_addr  in  NUM_BANKS*ADDR_WIDTH  bank b uses slice [b*ADDR_WIDTH +: ADDR_WIDTH]
req_wdata  in  NUM_BANKS*DATA_WIDTH  write data, sliced the same way
rsp_valid  out  NUM_BANKS  read data valid pulse
rsp_rdata  out  NUM_BANKS*DATA_WIDTH  read data
wr_err  out  NUM_BANKS  one-cycle pulse: write rejected, code > MAX_CODE

Behaviour:
Reset and reset values:
- On rst_n low: init_busy=0, init_done=0, req_ready=0, rsp_valid=0, rsp_rdata=0, wr_err=0.
- On rst_n low: read pipeline valids and the scrub counter clear.
- Memory arrays are not reset.

FSM states:
- S_SCRUB is entered on the first clock after rst_n deasserts.
- S_SCRUB is also entered on the cycle after init_start is sampled high in S_READY.
- S_SCRUB: init_busy=1 and req_ready=0.
- S_SCRUB: a counter runs 0..2**ADDR_WIDTH-1 and writes ZERO_CODE to that address in all banks in parallel.
- S_SCRUB: the scrub takes exactly 2**ADDR_WIDTH cycles.
- On the final write, init_done pulses for 1 cycle. On the next cycle the FSM enters S_READY, init_busy=0 and req_ready is all-ones.
- init_start is ignored while in S_SCRUB.

Request handshake:
- A request is accepted on a rising edge with req_valid[b] && req_ready[b].
- req_ready is registered. In S_READY it stays all-ones except that it drops the cycle after init_start is sampled.
- A request accepted in the same cycle init_start is sampled is fully honoured.

Reads:
- rsp_valid[b] and rsp_rdata slice are presented exactly READ_LATENCY cycles after acceptance.
- Fully pipelined: one read per cycle per bank. No response backpressure.
- rsp_rdata holds its last value when rsp_valid=0.

Writes:
- The write takes effect at the acceptance edge. A read of the same address accepted on the next cycle returns the new data.
- If wdata > MAX_CODE, memory is unchanged and wr_err[b] pulses on the cycle after acceptance.
- Writes produce no rsp_valid.

Banks and pipeline interaction:
- Banks are fully independent. Simultaneous requests on all banks are all accepted in one cycle.
- Reads in flight when a scrub starts still complete, returning pre-scrub data.

Reset mid-operation:
- rst_n low mid-scrub or mid-traffic clears all pipeline state at once and drops in-flight responses.
- On release a full scrub restarts from address 0.

Test Plan:
- ADDR_WIDTH=4, release rst_n -> init_busy=1 for 16 cycles, init_done pulses on the 16th; then read addr 0..15 in every bank -> all return 121.
- READ_LATENCY=1: write 0x55 to bank0 addr 3, read addr 3 on the next cycle -> rsp_valid[0] 1 cycle after acceptance, rdata=0x55. Repeat with READ_LATENCY=2 -> latency 2, back-to-back reads stream one per cycle.
- Write 243 to bank1 addr 7 -> wr_err[1] pulses 1 cycle later; read addr 7 -> 121 (unchanged). Write 242 -> no wr_err, read 242.
- NUM_BANKS=4, simultaneous writes of 10, 20, 30, 40 to addr 5 in banks 0..3, then simultaneous reads -> each bank returns its own value in the same cycle.
- Read bank0 addr 2 (holds 0x30) in the same cycle as init_start -> response 0x30 delivered; req_ready low next cycle for 2**ADDR_WIDTH cycles; then addr 2 reads 121.
- Drop rst_n at scrub count 8 -> all outputs 0 immediately; after release, init_busy lasts the full 2**ADDR_WIDTH cycles again.

Source files
------------

// File: rtl/ternary_sram_banked.sv
// ternary_sram_banked: NUM_BANKS independent single-port PT-5 ternary SRAM banks with
// post-reset zero scrub, 1- or 2-cycle read pipeline and write code validation.
module ternary_sram_banked #(
    parameter int NUM_BANKS    = 2,
    parameter int ADDR_WIDTH   = 12,
    parameter int DATA_WIDTH   = 8,
    parameter int READ_LATENCY = 1,
    parameter int ZERO_CODE    = 121,
    parameter int MAX_CODE     = 242
) (
    input  logic                             clk,
    input  logic                             rst_n,
    input  logic                             init_start,
    output logic                             init_busy,
    output logic                             init_done,
    input  logic [NUM_BANKS-1:0]             req_valid,
    output logic [NUM_BANKS-1:0]             req_ready,
    input  logic [NUM_BANKS-1:0]             req_we,
    input  logic [NUM_BANKS*ADDR_WIDTH-1:0]  req_addr,
    input  logic [NUM_BANKS*DATA_WIDTH-1:0]  req_wdata,
    output logic [NUM_BANKS-1:0]             rsp_valid,
    output logic [NUM_BANKS*DATA_WIDTH-1:0]  rsp_rdata,
    output logic [NUM_BANKS-1:0]             wr_err
);
    localparam int DEPTH = 1 << ADDR_WIDTH;

    typedef enum logic [1:0] {S_IDLE, S_SCRUB, S_READY} state_t;

    state_t                  state_q;
    logic [ADDR_WIDTH-1:0]   cnt_q;
    logic                    init_busy_q;
    logic                    init_done_q;
    logic [NUM_BANKS-1:0]    req_ready_q;
    logic                    scrub;

    assign scrub     = state_q == S_SCRUB;
    assign init_busy = init_busy_q;
    assign init_done = init_done_q;
    assign req_ready = req_ready_q;

    // Scrub writes address cnt_q at the edge closing each S_SCRUB cycle; done marks the last one.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= S_IDLE;
            cnt_q       <= '0;
            init_busy_q <= 1'b0;
            init_done_q <= 1'b0;
            req_ready_q <= '0;
        end else begin
            init_done_q <= 1'b0;
            case (state_q)
                S_IDLE: begin
                    state_q     <= S_SCRUB;
                    cnt_q       <= '0;
                    init_busy_q <= 1'b1;
                end
                S_SCRUB: begin
                    cnt_q <= cnt_q + ADDR_WIDTH'(1);
                    if (cnt_q == ADDR_WIDTH'(DEPTH - 2))
                        init_done_q <= 1'b1;
                    if (cnt_q == '1) begin
                        state_q     <= S_READY;
                        init_busy_q <= 1'b0;
                        req_ready_q <= '1;
                    end
                end
                default: begin
                    if (init_start) begin
                        state_q     <= S_SCRUB;
                        cnt_q       <= '0;
                        init_busy_q <= 1'b1;
                        req_ready_q <= '0;
                    end
                end
            endcase
        end
    end

    for (genvar b = 0; b < NUM_BANKS; b++) begin : g_bank
        logic [DATA_WIDTH-1:0]   mem [DEPTH];
        logic [ADDR_WIDTH-1:0]   addr;
        logic [DATA_WIDTH-1:0]   wdata;
        logic                    acc;
        logic                    bad;
        logic [READ_LATENCY-1:0] v_q;
        logic [DATA_WIDTH-1:0]   d_q [READ_LATENCY];
        logic                    err_q;

        assign addr  = req_addr[b*ADDR_WIDTH +: ADDR_WIDTH];
        assign wdata = req_wdata[b*DATA_WIDTH +: DATA_WIDTH];
        assign acc   = req_valid[b] & req_ready_q[b];
        assign bad   = wdata > DATA_WIDTH'(MAX_CODE);

        always_ff @(posedge clk) begin
            if (scrub)
                mem[cnt_q] <= DATA_WIDTH'(ZERO_CODE);
            else if (acc && req_we[b] && !bad)
                mem[addr] <= wdata;
        end

        // Data is captured at acceptance, so in-flight reads are immune to a later scrub.
        always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
                v_q   <= '0;
                err_q <= 1'b0;
                for (int i = 0; i < READ_LATENCY; i++)
                    d_q[i] <= '0;
            end else begin
                v_q[0] <= acc & ~req_we[b];
                if (acc && !req_we[b])
                    d_q[0] <= mem[addr];
                for (int i = 1; i < READ_LATENCY; i++) begin
                    v_q[i] <= v_q[i-1];
                    if (v_q[i-1])
                        d_q[i] <= d_q[i-1];
                end
                err_q <= acc & req_we[b] & bad;
            end
        end

        assign rsp_valid[b]                          = v_q[READ_LATENCY-1];
        assign rsp_rdata[b*DATA_WIDTH +: DATA_WIDTH] = d_q[READ_LATENCY-1];
        assign wr_err[b]                             = err_q;
    end

endmodule

// File: tb/tb_ternary_sram_banked.sv
// tb_ternary_sram_banked: directed checks of two 4-bank, 16-deep instances sharing
// stimulus, one with read latency 1 (a_*) and one with read latency 2 (b_*).
module tb_ternary_sram_banked;
    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        init_start = 1'b0;
    logic [3:0]  req_valid = '0, req_we = '0;
    logic [15:0] req_addr = '0;
    logic [31:0] req_wdata = '0;
    logic        a_busy, a_done, b_busy, b_done;
    logic [3:0]  a_ready, a_rv, a_err, b_ready, b_rv, b_err;
    logic [31:0] a_rd, b_rd;
    int checks = 0, errors = 0;

    always #5 clk = ~clk;

    ternary_sram_banked #(.NUM_BANKS(4), .ADDR_WIDTH(4), .READ_LATENCY(1)) u_a (
        .clk(clk), .rst_n(rst_n), .init_start(init_start), .init_busy(a_busy), .init_done(a_done),
        .req_valid(req_valid), .req_ready(a_ready), .req_we(req_we), .req_addr(req_addr),
        .req_wdata(req_wdata), .rsp_valid(a_rv), .rsp_rdata(a_rd), .wr_err(a_err));

    ternary_sram_banked #(.NUM_BANKS(4), .ADDR_WIDTH(4), .READ_LATENCY(2)) u_b (
        .clk(clk), .rst_n(rst_n), .init_start(init_start), .init_busy(b_busy), .init_done(b_done),
        .req_valid(req_valid), .req_ready(b_ready), .req_we(req_we), .req_addr(req_addr),
        .req_wdata(req_wdata), .rsp_valid(b_rv), .rsp_rdata(b_rd), .wr_err(b_err));

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic req(input logic [3:0] v, input logic [3:0] we, input logic [15:0] a, input logic [31:0] d);
        req_valid = v;
        req_we    = we;
        req_addr  = a;
        req_wdata = d;
    endtask

    task automatic scrub_check(input string tag);
        int busy_n = 0, done_n = 0, done_at = -1;
        for (int i = 0; i < 17; i++) begin
            @(negedge clk);
            if (a_busy) busy_n++;
            if (a_done) begin done_n++; done_at = i; end
        end
        chk({tag, "_busy_cycles"}, busy_n, 16);
        chk({tag, "_done_count"}, done_n, 1);
        chk({tag, "_done_at"}, done_at, 15);
        chk({tag, "_ready_after"}, a_ready, 4'hF);
        chk({tag, "_b_busy_after"}, b_busy, 0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int lowcnt;
        logic [3:0] ai;
        repeat (2) @(negedge clk);
        chk("rst_busy", a_busy, 0);
        chk("rst_done", a_done, 0);
        chk("rst_ready", a_ready, 0);
        chk("rst_rv", a_rv, 0);
        chk("rst_rd", a_rd, 0);
        chk("rst_err", a_err, 0);
        chk("rst_b_rd", b_rd, 0);
        rst_n = 1'b1;
        scrub_check("scrub0");

        for (int i = 0; i < 16; i++) begin
            ai = 4'(i);
            req(4'hF, 4'h0, {4{ai}}, 0);
            @(negedge clk);
            chk("scrub_rv", a_rv, 4'hF);
            chk("scrub_rd", a_rd, 32'h79797979);
        end
        req(0, 0, 0, 0);
        @(negedge clk);
        chk("scrub_b_rd", b_rd, 32'h79797979);

        req(4'h1, 4'h1, 16'h0003, 32'h55);
        @(negedge clk);
        chk("w55_no_err", a_err, 0);
        req(4'h1, 4'h0, 16'h0003, 0);
        @(negedge clk);
        chk("l1_rv", a_rv, 4'h1);
        chk("l1_rd", a_rd[7:0], 8'h55);
        chk("l2_rv_early", b_rv, 0);
        req(4'h1, 4'h0, 16'h0004, 0);
        @(negedge clk);
        chk("l1_rd2", a_rd[7:0], 8'd121);
        chk("l2_rv", b_rv, 4'h1);
        chk("l2_rd", b_rd[7:0], 8'h55);
        req(0, 0, 0, 0);
        @(negedge clk);
        chk("l1_rv_idle", a_rv, 0);
        chk("l1_rd_hold", a_rd[7:0], 8'd121);
        chk("l2_rv_stream", b_rv, 4'h1);
        chk("l2_rd_stream", b_rd[7:0], 8'd121);
        @(negedge clk);
        chk("l2_rv_idle", b_rv, 0);
        chk("l2_rd_hold", b_rd[7:0], 8'd121);

        req(4'h2, 4'h2, 16'h0070, 32'h0000F300);
        @(negedge clk);
        chk("w243_err", a_err, 4'h2);
        chk("w243_b_err", b_err, 4'h2);
        req(4'h2, 4'h0, 16'h0070, 0);
        @(negedge clk);
        chk("err_pulse_end", a_err, 0);
        chk("r7_rv", a_rv, 4'h2);
        chk("r7_unchanged", a_rd[15:8], 8'd121);
        req(4'h2, 4'h2, 16'h0070, 32'h0000F200);
        @(negedge clk);
        chk("w242_no_err", a_err, 0);
        req(4'h2, 4'h0, 16'h0070, 0);
        @(negedge clk);
        chk("r7_242", a_rd[15:8], 8'd242);

        req(4'hF, 4'hF, 16'h5555, 32'h281E140A);
        @(negedge clk);
        req(4'hF, 4'h0, 16'h5555, 0);
        @(negedge clk);
        chk("par_rv", a_rv, 4'hF);
        chk("par_rd", a_rd, 32'h281E140A);
        req(0, 0, 0, 0);
        @(negedge clk);
        chk("par_b_rv", b_rv, 4'hF);
        chk("par_b_rd", b_rd, 32'h281E140A);

        req(4'h1, 4'h1, 16'h0002, 32'h30);
        @(negedge clk);
        req(4'h1, 4'h0, 16'h0002, 0);
        init_start = 1'b1;
        @(negedge clk);
        init_start = 1'b0;
        req(0, 0, 0, 0);
        chk("ist_rv", a_rv, 4'h1);
        chk("ist_rd", a_rd[7:0], 8'h30);
        chk("ist_ready_low", a_ready, 0);
        chk("ist_busy", a_busy, 1);
        chk("ist_b_rv_early", b_rv, 0);
        lowcnt = 1;
        @(negedge clk);
        chk("ist_b_rv", b_rv, 4'h1);
        chk("ist_b_rd", b_rd[7:0], 8'h30);
        if (a_ready == 4'h0) lowcnt++;
        for (int i = 0; i < 30; i++) begin
            @(negedge clk);
            if (a_ready == 4'h0) lowcnt++;
            else break;
        end
        chk("ist_ready_low_cycles", lowcnt, 16);
        chk("ist_ready_back", a_ready, 4'hF);
        req(4'h1, 4'h0, 16'h0002, 0);
        @(negedge clk);
        chk("ist_rescrubbed", a_rd[7:0], 8'd121);
        req(0, 0, 0, 0);

        init_start = 1'b1;
        @(negedge clk);
        init_start = 1'b0;
        repeat (8) @(negedge clk);
        chk("mid_busy", a_busy, 1);
        rst_n = 1'b0;
        #1;
        chk("mid_rst_busy", a_busy, 0);
        chk("mid_rst_ready", a_ready, 0);
        chk("mid_rst_rd", a_rd, 0);
        chk("mid_rst_b_rd", b_rd, 0);
        chk("mid_rst_rv", a_rv, 0);
        @(negedge clk);
        rst_n = 1'b1;
        scrub_check("scrub1");

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
